btn_event_decoder: RTL and testbench
====================================

# btn_event_decoder

Classifies presses of a debounced push-button into single-click, double-click and long-press events. It sits directly downstream of the debouncer and consumes the debouncer's stable button level. It drives one-cycle event pulses to the control logic (LED/mode FSMs). All timing is counted in `clk` cycles; there is no internal prescaler.

## Interface
- `LONG_CYCLES`, default 50_000_000: hold time that qualifies a press as long; legal range ≥ 2.
- `GAP_CYCLES`, default 12_500_000: maximum released time between two presses of a double-click; legal range ≥ 1.
- `CNT_W`, default `$clog2(max(LONG_CYCLES, GAP_CYCLES) + 1)`: width of the duration counter; derived, not overridden.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_db`  in  1  debounced button level from the debouncer (1 = pressed); already synchronous to `clk`.
- `click_pls`  out  1  one-cycle pulse: single click.
- `dbl_click_pls`  out  1  one-cycle pulse: double click.
- `long_pls`  out  1  one-cycle pulse: long press.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Edge detection:
  - `btn_q` is `btn_db` delayed one cycle.
  - `rise = btn_db & ~btn_q`; `fall = ~btn_db & btn_q`.
- FSM states and transitions:
  - IDLE: on `rise`, go to PRESS1 and clear the counter.
  - PRESS1: counter increments each cycle while `btn_db` = 1.
    - If the counter reaches `LONG_CYCLES-1` with `btn_db` still 1: fire `long_pls` and go to LONG_HELD.
    - On `fall` before that: go to WAIT_GAP and clear the counter.
  - WAIT_GAP: counter increments each cycle.
    - On `rise`: go to PRESS2 and clear the counter.
    - If the counter reaches `GAP_CYCLES-1` with no rise: fire `click_pls` and go to IDLE.
  - PRESS2: counter increments while held.
    - On `fall`: fire `dbl_click_pls` and go to IDLE.
    - If the counter reaches `LONG_CYCLES-1`: fire `long_pls` and go to LONG_HELD. The pending first click is discarded.
  - LONG_HELD: no counting. On `fall`, go to IDLE with no pulse.
- Counter rules:
  - The counter is unsigned, `CNT_W` bits, and saturates at all-ones. It never wraps.
  - The counter is cleared on every state entry.
- At most one event pulse is high in any cycle; the three pulses are mutually exclusive by construction.
- Simultaneous events:
  - In WAIT_GAP, a `rise` in the same cycle as gap expiry takes priority. The result is PRESS2 and no `click_pls`.
  - In PRESS1/PRESS2, a `fall` in the same cycle as long expiry takes priority over the long-press path (release wins).

## Timing
- Reset values:
  - State = IDLE; counter = 0; all pulse outputs = 0; `busy` = 0.
  - `btn_q` resets to 1. A button held through reset is therefore ignored until it is released and pressed again.
- Reset mid-operation: `rst` high in any state returns to IDLE on the next edge and suppresses any pulse due that edge.
- Outputs are registered. Each pulse is high for exactly one cycle, in the cycle following the edge at which the qualifying condition was sampled.
- Latencies, with edge 0 being the edge where `rise` is sampled:
  - `long_pls` is high in the cycle after edge `LONG_CYCLES-1`.
  - `click_pls` is high `GAP_CYCLES` edges after the release is captured.
  - `dbl_click_pls` is high in the cycle after the second `fall` is captured.
- `busy` is registered and follows the state: it rises the cycle after `rise` and falls in the same cycle as the terminating pulse.

## Structure
- Package `btn_pkg`:
  - `btn_evt_state_t` enum {IDLE, PRESS1, WAIT_GAP, PRESS2, LONG_HELD}.
  - Localparam helper function for the `CNT_W` computation.
- Sub-module `btn_edge_det`:
  - Holds the `btn_q` register with reset value 1.
  - Produces `rise`/`fall`.
  - Reused by other button consumers.
- Top: FSM, duration counter and output pulse registers.

## Test plan
Bench parameters: `LONG_CYCLES` = 16, `GAP_CYCLES` = 8, 10 ns clock.
- Single click: `btn_db` high 5 cycles, then low. Required: exactly one `click_pls`, 8 cycles after the release is captured; no other pulse; `busy` low afterwards.
- Double click: high 4 cycles, low 3, high 4, low. Required: one `dbl_click_pls` the cycle after the second release; no `click_pls`.
- Long press: high 30 cycles. Required: `long_pls` once, at cycle 16 after the rise; no pulse on release; `busy` drops when released.
- Boundary cases:
  - Release at exactly cycle 15 gives a click, not a long press.
  - A second press arriving on the gap-expiry cycle gives a double click.
  - A second press held for 16 cycles gives only `long_pls`.
- Reset:
  - Assert `rst` during WAIT_GAP: no `click_pls`; `busy` = 0 next cycle.
  - Button held high across reset release: no event until it is released and pressed again.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button event decoder.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT_GAP,
    PRESS2,
    LONG_HELD
  } btn_evt_state_t;

  // Counter width large enough to hold the longer of the two timeouts.
  function automatic int cnt_width(input int long_cycles, input int gap_cycles);
    int max_cycles;
    max_cycles = (long_cycles > gap_cycles) ? long_cycles : gap_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/btn_edge_det.sv
// Rise/fall detector for a level already synchronous to clk.
// The delayed copy resets high so a level held through reset is not
// mistaken for a fresh press.
module btn_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic level_q;

  // One-cycle delayed copy of the input level.
  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b1;
    else     level_q <= level;
  end

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

endmodule

// File: rtl/btn_event_decoder.sv
// Classifies debounced button presses into click, double-click and long-press
// one-cycle pulses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a press
// PRESS1    | first press held, timing toward long press
// WAIT_GAP  | first press released, timing the gap for a second press
// PRESS2    | second press held, released -> double click, held -> long
// LONG_HELD | long press already reported, waiting for release
module btn_event_decoder
  import btn_pkg::*;
#(
  parameter int LONG_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_db,
  output logic click_pls,
  output logic dbl_click_pls,
  output logic long_pls,
  output logic busy
);

  localparam int CNT_W = cnt_width(LONG_CYCLES, GAP_CYCLES);
  // Terminal counts: the incremented counter value that ends each timeout.
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_CYCLES - 1);

  logic           rise;
  logic           fall;
  btn_evt_state_t state;
  btn_evt_state_t state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic           click_nxt;
  logic           dbl_nxt;
  logic           long_nxt;

  btn_edge_det u_edge (
    .clk   (clk),
    .rst   (rst),
    .level (btn_db),
    .rise  (rise),
    .fall  (fall)
  );

  // Saturating increment; the counter never wraps.
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

  // State, counter and registered outputs; reset suppresses any due pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      click_pls     <= 1'b0;
      dbl_click_pls <= 1'b0;
      long_pls      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      click_pls     <= click_nxt;
      dbl_click_pls <= dbl_nxt;
      long_pls      <= long_nxt;
      busy          <= (state_nxt != IDLE);
    end
  end

  // Next-state, counter and pulse decode; release beats long expiry and a
  // second press beats gap expiry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    click_nxt = 1'b0;
    dbl_nxt   = 1'b0;
    long_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESS1;
          cnt_nxt   = '0;
        end
      end
      PRESS1: begin
        if (fall) begin
          state_nxt = WAIT_GAP;
          cnt_nxt   = '0;
        end else if (btn_db && cnt_inc >= LONG_TC) begin
          long_nxt  = 1'b1;
          state_nxt = LONG_HELD;
          cnt_nxt   = '0;
        end else if (btn_db) begin
          cnt_nxt = cnt_inc;
        end
      end
      WAIT_GAP: begin
        if (rise) begin
          state_nxt = PRESS2;
          cnt_nxt   = '0;
        end else if (cnt_inc >= GAP_TC) begin
          click_nxt = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      PRESS2: begin
        if (fall) begin
          dbl_nxt   = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (btn_db && cnt_inc >= LONG_TC) begin
          long_nxt  = 1'b1;
          state_nxt = LONG_HELD;
          cnt_nxt   = '0;
        end else if (btn_db) begin
          cnt_nxt = cnt_inc;
        end
      end
      LONG_HELD: begin
        if (fall) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Scoreboard bench for btn_event_decoder: a timestamp-based reference model
// queues expected pulses, a negedge monitor pops and compares them.
module tb_btn_event_decoder;

  localparam int LONG_C = 16;
  localparam int GAP_C  = 8;
  localparam logic [2:0] K_CLICK = 3'b001;
  localparam logic [2:0] K_DBL   = 3'b010;
  localparam logic [2:0] K_LONG  = 3'b100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_db = 1'b0;
  logic click_pls, dbl_click_pls, long_pls, busy;

  btn_event_decoder #(.LONG_CYCLES(LONG_C), .GAP_CYCLES(GAP_C)) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_db        (btn_db),
    .click_pls     (click_pls),
    .dbl_click_pls (dbl_click_pls),
    .long_pls      (long_pls),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    logic [2:0] kind;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;
  logic exp_busy = 1'b0;

  // Reference model: an interaction is described by the edge at which the
  // current press or release started; events fire when elapsed time hits a limit.
  initial begin : model
    logic prev, active, pressing, long_done;
    int   presses, t0, held;
    prev = 1'b1; active = 1'b0; pressing = 1'b0; long_done = 1'b0;
    presses = 0; t0 = 0;
    forever begin
      @(posedge clk);
      edge_cnt++;
      if (rst) begin
        prev = 1'b1; active = 1'b0; pressing = 1'b0; long_done = 1'b0;
        presses = 0;
      end else begin
        held = edge_cnt - t0;
        if (!active) begin
          if (btn_db && !prev) begin
            active = 1'b1; pressing = 1'b1; long_done = 1'b0;
            presses = 1; t0 = edge_cnt;
          end
        end else if (long_done) begin
          if (!btn_db && prev) active = 1'b0;
        end else if (pressing) begin
          if (!btn_db && prev) begin
            if (presses == 1) begin
              pressing = 1'b0; t0 = edge_cnt;
            end else begin
              exp_q.push_back('{edge_cnt, K_DBL});
              active = 1'b0;
            end
          end else if (held >= LONG_C - 1) begin
            exp_q.push_back('{edge_cnt, K_LONG});
            long_done = 1'b1;
          end
        end else begin
          if (btn_db && !prev) begin
            presses = 2; pressing = 1'b1; t0 = edge_cnt;
          end else if (held >= GAP_C - 1) begin
            exp_q.push_back('{edge_cnt, K_CLICK});
            active = 1'b0;
          end
        end
        prev = btn_db;
      end
      exp_busy = active;
    end
  end

  // Monitor: compares busy every cycle and pulses against the queue head.
  initial begin : monitor
    logic [2:0] act;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (edge_cnt > 0) begin
        act = {long_pls, dbl_click_pls, click_pls};
        n_tests++;
        if (busy !== exp_busy) begin
          n_fail++;
          $display("FAIL busy @edge %0d: got %b expected %b", edge_cnt, busy, exp_busy);
        end
        if (exp_q.size() > 0 && exp_q[0].edge_no == edge_cnt) begin
          e = exp_q.pop_front();
          n_tests++;
          if (act !== e.kind) begin
            n_fail++;
            $display("FAIL event @edge %0d: got {long,dbl,click}=%b expected %b", edge_cnt, act, e.kind);
          end
        end else if (act !== 3'b000) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pulse @edge %0d: got {long,dbl,click}=%b expected 000", edge_cnt, act);
        end
      end
    end
  end

  task automatic drive(input logic lvl, input int n);
    btn_db = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Stimulus: directed cases first, then random press/release lengths.
  initial begin : stim
    logic lvl;
    rst = 1'b1;
    btn_db = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({long_pls, dbl_click_pls, click_pls, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state: got {long,dbl,click,busy}=%b expected 0000",
               {long_pls, dbl_click_pls, click_pls, busy});
    end
    rst = 1'b0;
    drive(1'b0, 5);

    // single click
    drive(1'b1, 5);  drive(1'b0, 20);
    // double click
    drive(1'b1, 4);  drive(1'b0, 3);  drive(1'b1, 4);  drive(1'b0, 20);
    // long press
    drive(1'b1, 30); drive(1'b0, 20);
    // release one cycle before long expiry
    drive(1'b1, 15); drive(1'b0, 20);
    // second press lands on the gap-expiry edge
    drive(1'b1, 4);  drive(1'b0, 7);  drive(1'b1, 4);  drive(1'b0, 20);
    // second press held to long expiry
    drive(1'b1, 4);  drive(1'b0, 3);  drive(1'b1, 16); drive(1'b0, 20);
    // reset during the gap wait
    drive(1'b1, 4);  drive(1'b0, 3);  do_reset(1);     drive(1'b0, 20);
    // button held across reset release
    btn_db = 1'b1;   do_reset(3);     drive(1'b1, 10);
    drive(1'b0, 5);  drive(1'b1, 4);  drive(1'b0, 20);

    lvl = 1'b1;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 19) == 0) do_reset(1);
      drive(lvl, $urandom_range(1, 20));
      lvl = ~lvl;
    end
    drive(1'b0, 40);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_events: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
